// File: rtl/fastio_ctrl.sv
// fastio_ctrl: Wishbone-classic register block for NPADS fast I/O pads.
// Holds the pad output/enable/strength registers, synchronizes the pad inputs
// and turns enabled rising/falling edges into sticky W1C status with a level irq.
module fastio_ctrl #(
    parameter int NPADS = 28
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NPADS-1:0] fastio_in,
    output logic [NPADS-1:0] fastio_out_l,
    output logic [NPADS-1:0] fastio_oe_l,
    output logic [NPADS-1:0] fastio_strong_enable,
    output logic [NPADS-1:0] fastio_med_enable,
    output logic             irq
);

    // Bus handshake states
    //   state    | meaning
    //   ST_IDLE  | no ack this cycle; a new access may start
    //   ST_ACK   | ack high for exactly one cycle; no access may start
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } bus_state_t;

    localparam logic [2:0] ADR_OUT     = 3'd0;
    localparam logic [2:0] ADR_OE      = 3'd1;
    localparam logic [2:0] ADR_STRONG  = 3'd2;
    localparam logic [2:0] ADR_MED     = 3'd3;
    localparam logic [2:0] ADR_IN      = 3'd4;
    localparam logic [2:0] ADR_RISE_IE = 3'd5;
    localparam logic [2:0] ADR_FALL_IE = 3'd6;
    localparam logic [2:0] ADR_STATUS  = 3'd7;

    bus_state_t       state;
    bus_state_t       state_nxt;

    logic             acc_start;
    logic             wr_en;
    logic             rd_en;
    logic [2:0]       acc_adr;
    logic [NPADS-1:0] wr_mask;
    logic [NPADS-1:0] wr_bits;
    logic [31:0]      rd_word;

    logic [NPADS-1:0] reg_out;
    logic [NPADS-1:0] reg_oe;
    logic [NPADS-1:0] reg_strong;
    logic [NPADS-1:0] reg_med;
    logic [NPADS-1:0] reg_rise_ie;
    logic [NPADS-1:0] reg_fall_ie;
    logic [NPADS-1:0] reg_status;

    logic [NPADS-1:0] sync1;
    logic [NPADS-1:0] sync2;
    logic [NPADS-1:0] prev;
    logic [NPADS-1:0] rise;
    logic [NPADS-1:0] fall;
    logic [NPADS-1:0] status_set;
    logic [NPADS-1:0] status_clr;

    // Address bits outside [4:2] and data bits above NPADS are intentionally ignored.
    logic unused_bus;
    assign unused_bus = &{1'b0, wbs_adr_i, wbs_dat_i};

    assign acc_adr   = wbs_adr_i[4:2];
    assign acc_start = wbs_stb_i & wbs_cyc_i & (state == ST_IDLE);
    assign wr_en     = acc_start & wbs_we_i;
    assign rd_en     = acc_start & ~wbs_we_i;
    assign wbs_ack_o = (state == ST_ACK);

    for (genvar g = 0; g < NPADS; g++) begin : g_mask
        assign wr_mask[g] = wbs_sel_i[g / 8];
    end
    assign wr_bits = wbs_dat_i[NPADS-1:0] & wr_mask;

    function automatic logic [NPADS-1:0] merge_bytes(input logic [NPADS-1:0] old_val,
                                                      input logic [NPADS-1:0] new_bits,
                                                      input logic [NPADS-1:0] mask);
        return (old_val & ~mask) | new_bits;
    endfunction

    // Handshake state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next state: one ack cycle per access, then a mandatory idle cycle.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (acc_start) state_nxt = ST_ACK;
            ST_ACK:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Read mux, zero-extended to the bus width.
    always_comb begin
        rd_word = '0;
        case (acc_adr)
            ADR_OUT:     rd_word[NPADS-1:0] = reg_out;
            ADR_OE:      rd_word[NPADS-1:0] = reg_oe;
            ADR_STRONG:  rd_word[NPADS-1:0] = reg_strong;
            ADR_MED:     rd_word[NPADS-1:0] = reg_med;
            ADR_IN:      rd_word[NPADS-1:0] = sync2;
            ADR_RISE_IE: rd_word[NPADS-1:0] = reg_rise_ie;
            ADR_FALL_IE: rd_word[NPADS-1:0] = reg_fall_ie;
            ADR_STATUS:  rd_word[NPADS-1:0] = reg_status;
            default:     rd_word = '0;
        endcase
    end

    // Read data is captured with the ack and is zero in every other cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     wbs_dat_o <= '0;
        else if (rd_en) wbs_dat_o <= rd_word;
        else            wbs_dat_o <= '0;
    end

    // Control registers; writes land on the same edge that raises ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_out     <= '0;
            reg_oe      <= '0;
            reg_strong  <= '0;
            reg_med     <= '0;
            reg_rise_ie <= '0;
            reg_fall_ie <= '0;
        end else if (wr_en) begin
            case (acc_adr)
                ADR_OUT:     reg_out     <= merge_bytes(reg_out,     wr_bits, wr_mask);
                ADR_OE:      reg_oe      <= merge_bytes(reg_oe,      wr_bits, wr_mask);
                ADR_STRONG:  reg_strong  <= merge_bytes(reg_strong,  wr_bits, wr_mask);
                ADR_MED:     reg_med     <= merge_bytes(reg_med,     wr_bits, wr_mask);
                ADR_RISE_IE: reg_rise_ie <= merge_bytes(reg_rise_ie, wr_bits, wr_mask);
                ADR_FALL_IE: reg_fall_ie <= merge_bytes(reg_fall_ie, wr_bits, wr_mask);
                default: ;
            endcase
        end
    end

    // Two-flop synchronizer plus one history flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= fastio_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise       = sync2 & ~prev;
    assign fall       = ~sync2 & prev;
    assign status_set = (rise & reg_rise_ie) | (fall & reg_fall_ie);
    assign status_clr = (wr_en && acc_adr == ADR_STATUS) ? wr_bits : '0;

    // Sticky status: a new event in the same cycle as a W1C keeps the bit set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_status <= '0;
        else        reg_status <= (reg_status & ~status_clr) | status_set;
    end

    // Registered interrupt, one cycle behind status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= |reg_status;
    end

    assign fastio_out_l         = ~reg_out;
    assign fastio_oe_l          = ~reg_oe;
    assign fastio_strong_enable = reg_strong;
    assign fastio_med_enable    = reg_med;

endmodule
